dk_sound_mixer: RTL and testbench

- Output stage of the discrete sound section; sits directly downstream of the per-effect discrete circuits (walk, jump, stomp, etc.).
- Takes one signed 16-bit sample per effect and produces one signed 16-bit mixed sample per audio tick.
- Each channel is weighted by a fixed gain; the sum is saturated to 16 bits.
- Uses a single time-multiplexed multiply-accumulate instead of N parallel multipliers.

---
 rtl/dk_audio_pkg.sv | 25 ++
 rtl/dk_mix_mac.sv | 42 ++++
 rtl/dk_sound_mixer.sv | 170 +++++++++++++++++
 tb/tb_dk_sound_mixer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/dk_audio_pkg.sv
// Shared audio types, limits and the 16-bit saturation helpers for the discrete sound section.
package dk_audio_pkg;

  typedef logic signed [15:0] sample_t;

  localparam int S16_MAX     = 32767;
  localparam int S16_MIN     = -32768;
  localparam int GAIN_Q8_ONE = 256;

  // Callers sign-extend into 28 bits, wide enough for the largest mixer accumulator.
  function automatic sample_t sat16(input logic signed [27:0] acc);
    if (acc > 28'sd32767) begin
      sat16 = 16'sh7FFF;
    end else if (acc < -28'sd32768) begin
      sat16 = 16'sh8000;
    end else begin
      sat16 = acc[15:0];
    end
  endfunction

  function automatic logic is_clip16(input logic signed [27:0] acc);
    is_clip16 = (acc > 28'sd32767) || (acc < -28'sd32768);
  endfunction

endpackage

// File: rtl/dk_mix_mac.sv
// Registered multiply-accumulate: one signed sample times one Q0.8 gain per enabled clock.
module dk_mix_mac
  import dk_audio_pkg::*;
#(
  parameter int ACC_W = 27
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  sample_t                 sample_i,
  input  logic [7:0]              gain_i,
  output logic signed [ACC_W-1:0] acc_o
);

  logic signed [24:0]      prod_s;
  logic signed [ACC_W-1:0] acc_d, acc_q;

  // Gain is zero-extended so 255/256 stays positive in the signed product.
  assign prod_s = sample_i * $signed({1'b0, gain_i});

  always_comb begin
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + ACC_W'(prod_s);
    end else begin
      acc_d = acc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/dk_sound_mixer.sv
// Discrete sound output mixer: snapshots NUM_CH samples per tick, time-multiplexes one MAC, saturates.
// Optional clip_count output enabled by defining DK_MIXER_CLIP_COUNT_EN.
module dk_sound_mixer
  import dk_audio_pkg::*;
#(
  parameter int                  CLOCK_RATE  = 1000000,
  parameter int                  SAMPLE_RATE = 48000,
  parameter int                  NUM_CH      = 4,
  parameter logic [NUM_CH*8-1:0] GAINS_Q8    = {NUM_CH{8'd128}}
) (
  input  logic                     clk,
  input  logic                     I_RSTn,
  input  logic                     audio_clk_en,
  input  logic [NUM_CH*16-1:0]     in_ch,
  input  logic                     mute,
  output logic signed [15:0]       out,
  output logic                     out_valid,
  output logic                     overrun
`ifdef DK_MIXER_CLIP_COUNT_EN
  ,
  output logic [15:0]              clip_count
`endif
);

  localparam int ACC_W = 25 + $clog2(NUM_CH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_SAT  = 2'd2;

  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
    $error("dk_sound_mixer: NUM_CH must be in 1..8");
  end
  if (CLOCK_RATE / SAMPLE_RATE < NUM_CH + 2) begin : g_bad_rate
    $error("dk_sound_mixer: too few clocks per sample for NUM_CH+2 cycle mix");
  end

  logic [1:0]              state_q, state_d;
  logic [2:0]              idx_q, idx_d;
  sample_t                 snap_q [NUM_CH];
  logic                    snap_en_s, mac_clr_s, mac_en_s, last_s;
  sample_t                 mac_sample_s;
  logic [7:0]              mac_gain_s;
  logic signed [ACC_W-1:0] acc_s, shifted_s;
  logic signed [27:0]      sat_in_s;
  sample_t                 sat_s;
  sample_t                 out_q, out_d;
  logic                    out_valid_q, out_valid_d;
  logic                    overrun_q, overrun_d;

  assign last_s    = (idx_q == 3'(NUM_CH - 1));
  assign shifted_s = acc_s >>> 8;
  assign sat_in_s  = 28'(shifted_s);
  assign sat_s     = sat16(sat_in_s);

  always_comb begin
    mac_sample_s = '0;
    mac_gain_s   = 8'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      mac_sample_s = (idx_q == 3'(i)) ? snap_q[i] : mac_sample_s;
      mac_gain_s   = (idx_q == 3'(i)) ? GAINS_Q8[i*8 +: 8] : mac_gain_s;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    snap_en_s   = 1'b0;
    mac_clr_s   = 1'b0;
    mac_en_s    = 1'b0;
    out_d       = out_q;
    out_valid_d = 1'b0;
    overrun_d   = overrun_q;
    case (state_q)
      ST_IDLE: begin
        if (audio_clk_en) begin
          state_d   = ST_ACC;
          idx_d     = 3'd0;
          snap_en_s = 1'b1;
          mac_clr_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACC: begin
        mac_en_s  = 1'b1;
        idx_d     = idx_q + 3'd1;
        state_d   = last_s ? ST_SAT : ST_ACC;
        overrun_d = overrun_q | audio_clk_en;
      end
      ST_SAT: begin
        out_d       = mute ? 16'sd0 : sat_s;
        out_valid_d = 1'b1;
        state_d     = ST_IDLE;
        overrun_d   = overrun_q | audio_clk_en;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state_q     <= ST_IDLE;
      idx_q       <= 3'd0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  // Inputs are frozen at the tick so later changes cannot leak into the mix in flight.
  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      for (int i = 0; i < NUM_CH; i++) snap_q[i] <= '0;
    end else if (snap_en_s) begin
      for (int i = 0; i < NUM_CH; i++) snap_q[i] <= in_ch[i*16 +: 16];
    end
  end

  dk_mix_mac #(
    .ACC_W(ACC_W)
  ) u_mac (
    .clk      (clk),
    .rst_n    (I_RSTn),
    .clr_i    (mac_clr_s),
    .en_i     (mac_en_s),
    .sample_i (mac_sample_s),
    .gain_i   (mac_gain_s),
    .acc_o    (acc_s)
  );

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

`ifdef DK_MIXER_CLIP_COUNT_EN
  logic        clip_s;
  logic [15:0] clip_cnt_q, clip_cnt_d;

  assign clip_s = is_clip16(sat_in_s);

  // Counts clamps even when the output is muted; sticks at all-ones.
  always_comb begin
    if ((state_q == ST_SAT) && clip_s && (clip_cnt_q != 16'hFFFF)) begin
      clip_cnt_d = clip_cnt_q + 16'd1;
    end else begin
      clip_cnt_d = clip_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      clip_cnt_q <= 16'd0;
    end else begin
      clip_cnt_q <= clip_cnt_d;
    end
  end

  assign clip_count = clip_cnt_q;
`endif

endmodule

// File: tb/tb_dk_sound_mixer.sv
// Directed self-checking bench for dk_sound_mixer: two instances (gains 128 and 255) share stimulus.
module tb_dk_sound_mixer;

  logic               clk = 1'b0;
  logic               I_RSTn;
  logic               audio_clk_en;
  logic [63:0]        in_ch;
  logic               mute;
  logic signed [15:0] out_a, out_b;
  logic               valid_a, valid_b, ovr_a, ovr_b;
`ifdef DK_MIXER_CLIP_COUNT_EN
  logic [15:0]        clip_a, clip_b;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dk_sound_mixer #(
    .NUM_CH   (4),
    .GAINS_Q8 ({4{8'd128}})
  ) u_dut_a (
    .clk          (clk),
    .I_RSTn       (I_RSTn),
    .audio_clk_en (audio_clk_en),
    .in_ch        (in_ch),
    .mute         (mute),
    .out          (out_a),
    .out_valid    (valid_a),
    .overrun      (ovr_a)
`ifdef DK_MIXER_CLIP_COUNT_EN
    ,
    .clip_count   (clip_a)
`endif
  );

  dk_sound_mixer #(
    .NUM_CH   (4),
    .GAINS_Q8 ({4{8'd255}})
  ) u_dut_b (
    .clk          (clk),
    .I_RSTn       (I_RSTn),
    .audio_clk_en (audio_clk_en),
    .in_ch        (in_ch),
    .mute         (mute),
    .out          (out_b),
    .out_valid    (valid_b),
    .overrun      (ovr_b)
`ifdef DK_MIXER_CLIP_COUNT_EN
    ,
    .clip_count   (clip_b)
`endif
  );

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pack4(input int c0, input int c1, input int c2, input int c3);
    logic [31:0] v0, v1, v2, v3;
    v0 = c0; v1 = c1; v2 = c2; v3 = c3;
    return {v3[15:0], v2[15:0], v1[15:0], v0[15:0]};
  endfunction

  // Issue one tick, optionally change inputs right after capture, wait for the result.
  task automatic do_tick(input string tag, input logic [63:0] vec, input logic [63:0] vec_after,
                         input logic m, input int exp_a, input int exp_b);
    int lat;
    @(negedge clk);
    in_ch = vec;
    mute = m;
    audio_clk_en = 1'b1;
    @(negedge clk);
    audio_clk_en = 1'b0;
    in_ch = vec_after;
    lat = 0;
    while (!valid_a && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, 5);
    check({tag, "_out_a"}, out_a, exp_a);
    check({tag, "_out_b"}, out_b, exp_b);
    check({tag, "_valid_b"}, {31'd0, valid_b}, 1);
    @(negedge clk);
    check({tag, "_pulse_end"}, {31'd0, valid_a}, 0);
    check({tag, "_hold"}, out_a, exp_a);
    mute = 1'b0;
  endtask

  initial begin
    int extra;
    I_RSTn = 1'b0;
    audio_clk_en = 1'b0;
    in_ch = 64'd0;
    mute = 1'b0;
    #1;
    check("rst_out", out_a, 0);
    check("rst_valid", {31'd0, valid_a}, 0);
    check("rst_overrun", {31'd0, ovr_a}, 0);
    repeat (3) @(negedge clk);
    I_RSTn = 1'b1;

    do_tick("basic", pack4(1000, 2000, -500, 0), pack4(1000, 2000, -500, 0), 1'b0, 1250, 2490);
    check("basic_overrun", {31'd0, ovr_a}, 0);
    do_tick("neg_floor", pack4(-3, 0, 0, 0), pack4(-3, 0, 0, 0), 1'b0, -2, -3);
    do_tick("snapshot", pack4(4000, 0, 0, 0), pack4(-4000, 0, 0, 0), 1'b0, 2000, 3984);
    do_tick("mute_on", pack4(1000, 1000, 1000, 1000), pack4(1000, 1000, 1000, 1000), 1'b1, 0, 0);
    do_tick("mute_off", pack4(1000, 1000, 1000, 1000), pack4(1000, 1000, 1000, 1000), 1'b0, 2000, 3984);
    do_tick("sat_max", pack4(32767, 32767, 32767, 32767), pack4(32767, 32767, 32767, 32767), 1'b0, 32767, 32767);
    do_tick("sat_min", pack4(-32768, -32768, -32768, -32768), pack4(-32768, -32768, -32768, -32768), 1'b0, -32768, -32768);
`ifdef DK_MIXER_CLIP_COUNT_EN
    check("clip_count_a", {16'd0, clip_a}, 2);
    check("clip_count_b", {16'd0, clip_b}, 2);
`endif

    // Second tick lands two clocks into the mix and must be dropped.
    @(negedge clk);
    in_ch = pack4(1000, 2000, -500, 0);
    audio_clk_en = 1'b1;
    @(negedge clk);
    audio_clk_en = 1'b0;
    @(negedge clk);
    audio_clk_en = 1'b1;
    @(negedge clk);
    audio_clk_en = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_valid", {31'd0, valid_a}, 1);
    check("busy_out", out_a, 1250);
    check("busy_overrun", {31'd0, ovr_a}, 1);
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (valid_a) extra++;
    end
    check("busy_no_second", extra, 0);
    do_tick("after_busy", pack4(1000, 2000, -500, 0), pack4(1000, 2000, -500, 0), 1'b0, 1250, 2490);
    check("overrun_sticky_a", {31'd0, ovr_a}, 1);
    check("overrun_sticky_b", {31'd0, ovr_b}, 1);

    // Reset in the middle of a mix.
    @(negedge clk);
    in_ch = pack4(4000, 0, 0, 0);
    audio_clk_en = 1'b1;
    @(negedge clk);
    audio_clk_en = 1'b0;
    @(negedge clk);
    I_RSTn = 1'b0;
    #1;
    check("midrst_out", out_a, 0);
    check("midrst_valid", {31'd0, valid_a}, 0);
    check("midrst_overrun", {31'd0, ovr_a}, 0);
`ifdef DK_MIXER_CLIP_COUNT_EN
    check("midrst_clip", {16'd0, clip_b}, 0);
`endif
    repeat (2) @(negedge clk);
    I_RSTn = 1'b1;
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (valid_a) extra++;
    end
    check("midrst_no_partial", extra, 0);
    do_tick("post_rst", pack4(256, 0, 0, 0), pack4(256, 0, 0, 0), 1'b0, 128, 255);
    check("post_rst_overrun", {31'd0, ovr_a}, 0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
